// File: rtl/pe_win_pkg.sv
// Shared types and constants for the priority-evaluation window unit.
package pe_win_pkg;

    localparam int unsigned DEF_NUM_WIN    = 2;
    localparam int unsigned DEF_NUM_LAYERS = 5;
    localparam int unsigned DEF_COORD_W    = 8;
    localparam int unsigned DEF_V_LINES    = 228;
    localparam int unsigned DEF_H_PIX      = 240;

    // Control word = one enable per layer plus the colour-effects bit
    function automatic int unsigned pe_ctl_w(input int unsigned num_layers);
        return num_layers + 1;
    endfunction

    localparam int unsigned PE_CTL_W = pe_ctl_w(DEF_NUM_LAYERS);

    typedef enum logic [2:0] {
        LAYER_BG0 = 3'd0,
        LAYER_BG1 = 3'd1,
        LAYER_BG2 = 3'd2,
        LAYER_BG3 = 3'd3,
        LAYER_OBJ = 3'd4
    } pe_layer_e;

    typedef struct packed {
        logic                      effects;
        logic [DEF_NUM_LAYERS-1:0] layers;
    } pe_win_ctl_t;

endpackage

// File: rtl/pe_win_range_cmp.sv
// Wrap-aware half-open range test: lo<hi is [lo,hi), lo>hi wraps, lo==hi is empty.
module pe_win_range_cmp
    import pe_win_pkg::*;
#(
    parameter int unsigned W = DEF_COORD_W
) (
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] p_i,
    output logic         in_range_c
);

    always_comb begin
        in_range_c = 1'b0;
        if (lo_i < hi_i) begin
            in_range_c = (p_i >= lo_i) && (p_i < hi_i);
        end else if (lo_i > hi_i) begin
            in_range_c = (p_i >= lo_i) || (p_i < hi_i);
        end
    end

endmodule

// File: rtl/pe_window_unit.sv
// Per-pixel window evaluator: beam counters, window hit test, priority select, 2-stage pipeline.
// Optional PE_WIN_SHADOW_EN latches the window configuration on frame_start.
module pe_window_unit
    import pe_win_pkg::*;
#(
    parameter int unsigned NUM_WIN    = DEF_NUM_WIN,
    parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int unsigned COORD_W    = DEF_COORD_W,
    parameter int unsigned V_LINES    = DEF_V_LINES
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              frame_start,
    input  logic                              line_start,
    input  logic                              pix_valid,
    input  logic                              obj_win,
    input  logic [NUM_WIN:0]                  win_en,
    input  logic [NUM_LAYERS-1:0]             layer_en,
    input  logic [NUM_WIN*COORD_W-1:0]        win_x1,
    input  logic [NUM_WIN*COORD_W-1:0]        win_x2,
    input  logic [NUM_WIN*COORD_W-1:0]        win_y1,
    input  logic [NUM_WIN*COORD_W-1:0]        win_y2,
    input  logic [NUM_WIN*(NUM_LAYERS+1)-1:0] win_ctl,
    input  logic [NUM_LAYERS:0]               obj_ctl,
    input  logic [NUM_LAYERS:0]               out_ctl,
    output logic [NUM_LAYERS-1:0]             mask_out,
    output logic                              effects_out,
    output logic                              out_valid,
    output logic [NUM_WIN:0]                  win_hit
);

    localparam int unsigned CTL_W = pe_ctl_w(NUM_LAYERS);
    localparam int unsigned BND_W = NUM_WIN * COORD_W;
    localparam logic [COORD_W-1:0] X_MAX  = '1;
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_LINES - 1);

    logic [COORD_W-1:0]       x_q, x_d, y_q, y_d, x_cur, y_cur;
    logic [NUM_WIN:0]         en_s1;
    logic [BND_W-1:0]         x1_s1, x2_s1, y1_s1, y2_s1;
    logic [NUM_LAYERS-1:0]    layer_s2;
    logic [NUM_WIN*CTL_W-1:0] wctl_s2;
    logic [CTL_W-1:0]         octl_s2, uctl_s2;

`ifdef PE_WIN_SHADOW_EN
    logic [NUM_WIN:0]         sh_en_q;
    logic [NUM_LAYERS-1:0]    sh_layer_q;
    logic [BND_W-1:0]         sh_x1_q, sh_x2_q, sh_y1_q, sh_y2_q;
    logic [NUM_WIN*CTL_W-1:0] sh_wctl_q;
    logic [CTL_W-1:0]         sh_octl_q, sh_uctl_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_en_q    <= '0;
            sh_layer_q <= '0;
            sh_x1_q    <= '0;
            sh_x2_q    <= '0;
            sh_y1_q    <= '0;
            sh_y2_q    <= '0;
            sh_wctl_q  <= '0;
            sh_octl_q  <= '0;
            sh_uctl_q  <= '0;
        end else if (frame_start) begin
            sh_en_q    <= win_en;
            sh_layer_q <= layer_en;
            sh_x1_q    <= win_x1;
            sh_x2_q    <= win_x2;
            sh_y1_q    <= win_y1;
            sh_y2_q    <= win_y2;
            sh_wctl_q  <= win_ctl;
            sh_octl_q  <= obj_ctl;
            sh_uctl_q  <= out_ctl;
        end
    end

    // A pixel in the frame_start cycle already belongs to the new frame
    assign en_s1    = frame_start ? win_en : sh_en_q;
    assign x1_s1    = frame_start ? win_x1 : sh_x1_q;
    assign x2_s1    = frame_start ? win_x2 : sh_x2_q;
    assign y1_s1    = frame_start ? win_y1 : sh_y1_q;
    assign y2_s1    = frame_start ? win_y2 : sh_y2_q;
    assign layer_s2 = sh_layer_q;
    assign wctl_s2  = sh_wctl_q;
    assign octl_s2  = sh_octl_q;
    assign uctl_s2  = sh_uctl_q;
`else
    assign en_s1    = win_en;
    assign x1_s1    = win_x1;
    assign x2_s1    = win_x2;
    assign y1_s1    = win_y1;
    assign y2_s1    = win_y2;
    assign layer_s2 = layer_en;
    assign wctl_s2  = win_ctl;
    assign octl_s2  = obj_ctl;
    assign uctl_s2  = out_ctl;
`endif

    // Position of the pixel evaluated this cycle; frame_start overrides line_start
    always_comb begin
        y_cur = y_q;
        if (frame_start) begin
            y_cur = '0;
        end else if (line_start) begin
            y_cur = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
        end
        x_cur = line_start ? '0 : x_q;
        x_d   = x_cur;
        if (pix_valid && (x_cur != X_MAX)) begin
            x_d = x_cur + COORD_W'(1);
        end
        y_d = y_cur;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic [NUM_WIN-1:0] hit_c;

    for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
        logic x_in, y_in;

        pe_win_range_cmp #(.W(COORD_W)) u_x_cmp (
            .lo_i       (x1_s1[i*COORD_W +: COORD_W]),
            .hi_i       (x2_s1[i*COORD_W +: COORD_W]),
            .p_i        (x_cur),
            .in_range_c (x_in)
        );

        pe_win_range_cmp #(.W(COORD_W)) u_y_cmp (
            .lo_i       (y1_s1[i*COORD_W +: COORD_W]),
            .hi_i       (y2_s1[i*COORD_W +: COORD_W]),
            .p_i        (y_cur),
            .in_range_c (y_in)
        );

        assign hit_c[i] = en_s1[i] & x_in & y_in;
    end

    logic [NUM_WIN-1:0] hit1_q;
    logic               obj1_q, none1_q, vld1_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit1_q  <= '0;
            obj1_q  <= 1'b0;
            none1_q <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            hit1_q  <= hit_c;
            obj1_q  <= obj_win & en_s1[NUM_WIN];
            none1_q <= ~|en_s1;
            vld1_q  <= pix_valid;
        end
    end

    logic [NUM_LAYERS-1:0] mask_d;
    logic                  effects_d;
    logic [NUM_WIN:0]      hit_d;
    logic [CTL_W-1:0]      sel_ctl;
    logic [NUM_WIN:0]      sel_hit;
    logic                  found;

    // Priority: lowest window index, then OBJ window, then outside
    always_comb begin
        sel_ctl = uctl_s2;
        sel_hit = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (!found && hit1_q[i]) begin
                found      = 1'b1;
                sel_ctl    = wctl_s2[i*CTL_W +: CTL_W];
                sel_hit    = '0;
                sel_hit[i] = 1'b1;
            end
        end
        if (!found && obj1_q) begin
            sel_ctl          = octl_s2;
            sel_hit          = '0;
            sel_hit[NUM_WIN] = 1'b1;
        end

        mask_d    = layer_s2 & sel_ctl[NUM_LAYERS-1:0];
        effects_d = sel_ctl[NUM_LAYERS];
        hit_d     = sel_hit;
        if (none1_q) begin
            mask_d    = layer_s2;
            effects_d = 1'b1;
            hit_d     = '0;
        end
        if (!vld1_q) begin
            mask_d    = mask_out;
            effects_d = effects_out;
            hit_d     = win_hit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mask_out    <= '0;
            effects_out <= 1'b0;
            win_hit     <= '0;
            out_valid   <= 1'b0;
        end else begin
            mask_out    <= mask_d;
            effects_out <= effects_d;
            win_hit     <= hit_d;
            out_valid   <= vld1_q;
        end
    end

endmodule

// File: tb/tb_pe_window_unit.sv
// Self-checking bench for pe_window_unit: directed vector table, corner sequences, random frames vs model.
module tb_pe_window_unit;
    import pe_win_pkg::*;

    localparam int VL = DEF_V_LINES;

    typedef struct packed {
        logic [2:0]      en;
        logic [4:0]      layer;
        logic [1:0][7:0] x1;
        logic [1:0][7:0] x2;
        logic [1:0][7:0] y1;
        logic [1:0][7:0] y2;
        logic [1:0][5:0] wctl;
        logic [5:0]      octl;
        logic [5:0]      uctl;
    } cfg_t;

    typedef struct packed {
        logic [4:0] mask;
        logic       eff;
        logic [2:0] hit;
    } res_t;

    typedef struct {
        string name;
        cfg_t  c;
        int    x;
        int    y;
        bit    ow;
        res_t  exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0, line_start = 1'b0, pix_valid = 1'b0, obj_win = 1'b0;
    logic [4:0]  mask_out;
    logic        effects_out, out_valid;
    logic [2:0]  win_hit;
    cfg_t        cfg = '0;

    int errors = 0;
    int checks = 0;

    pe_window_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .line_start  (line_start),
        .pix_valid   (pix_valid),
        .obj_win     (obj_win),
        .win_en      (cfg.en),
        .layer_en    (cfg.layer),
        .win_x1      (cfg.x1),
        .win_x2      (cfg.x2),
        .win_y1      (cfg.y1),
        .win_y2      (cfg.y2),
        .win_ctl     (cfg.wctl),
        .obj_ctl     (cfg.octl),
        .out_ctl     (cfg.uctl),
        .mask_out    (mask_out),
        .effects_out (effects_out),
        .out_valid   (out_valid),
        .win_hit     (win_hit)
    );

    always #5 clock = ~clock;

    // Reference model state: beam position, shadow copy, expected-result queue
    int   mx = 0, my = 0;
    cfg_t sh = '0;
    res_t exp_q[$];
    logic pv1, pv2;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(int lo, int hi, int p);
        if (lo < hi) return (p >= lo) && (p < hi);
        if (lo > hi) return (p >= lo) || (p < hi);
        return 1'b0;
    endfunction

    function automatic res_t eval(cfg_t c, int x, int y, bit ow);
        res_t       r;
        logic [5:0] ctl;
        bit         found;
        r     = '0;
        found = 1'b0;
        ctl   = c.uctl;
        if (c.en == 3'b000) begin
            r.mask = c.layer;
            r.eff  = 1'b1;
            return r;
        end
        for (int i = 0; i < 2; i++) begin
            if (!found && c.en[i] && in_rng(int'(c.x1[i]), int'(c.x2[i]), x)
                && in_rng(int'(c.y1[i]), int'(c.y2[i]), y)) begin
                found = 1'b1;
                ctl   = c.wctl[i];
                r.hit = (i == 0) ? 3'b001 : 3'b010;
            end
        end
        if (!found && ow && c.en[2]) begin
            ctl   = c.octl;
            r.hit = 3'b100;
        end
        r.mask = c.layer & ctl[4:0];
        r.eff  = ctl[5];
        return r;
    endfunction

    // Apply one cycle of stimulus and advance the model accordingly
    task automatic drive(bit fs, bit ls, bit pv, bit ow);
        cfg_t use_c;
        frame_start = fs;
        line_start  = ls;
        pix_valid   = pv;
        obj_win     = ow;
        if (fs) begin
            sh = cfg;
            my = 0;
        end else if (ls) begin
            my = (my + 1) % VL;
        end
        if (ls) mx = 0;
`ifdef PE_WIN_SHADOW_EN
        use_c = sh;
`else
        use_c = cfg;
`endif
        if (pv) begin
            exp_q.push_back(eval(use_c, mx, my, ow));
            if (mx < 255) mx++;
        end
        @(negedge clock);
    endtask

    task automatic goto_xy(int x, int y);
        drive(1, 1, 0, 0);
        repeat (y) drive(0, 1, 0, 0);
        repeat (x) drive(0, 0, 1, 0);
    endtask

    task automatic run_vec(vec_t v);
        cfg = v.c;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        goto_xy(v.x, v.y);
        drive(0, 0, 1, v.ow);
        drive(0, 0, 0, 0);
        check(v.name, {out_valid, mask_out, effects_out, win_hit}, {1'b1, v.exp});
    endtask

    function automatic vec_t mk(string n, cfg_t c, int x, int y, bit ow,
                                logic [4:0] m, logic e, logic [2:0] h);
        vec_t v;
        v.name = n;
        v.c    = c;
        v.x    = x;
        v.y    = y;
        v.ow   = ow;
        v.exp  = res_t'{mask: m, eff: e, hit: h};
        return v;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv1 <= 1'b0;
            pv2 <= 1'b0;
        end else begin
            pv1 <= pix_valid;
            pv2 <= pv1;
        end
    end

    // Continuous scoreboard: out_valid timing and every produced pixel result
    always @(negedge clock) begin
        if (reset_n) begin
            check("out_valid_timing", 32'(out_valid), 32'(pv2));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got unexpected pixel mask=%b hit=%b", mask_out, win_hit);
                end else begin
                    check("pixel", {mask_out, effects_out, win_hit}, exp_q.pop_front());
                end
            end
        end
    end

    vec_t vecs[$];
    cfg_t t1, t2, t3, t4;

    initial begin
        // Window geometry / gating configuration
        t1 = '0;
        t1.en = 3'b001;  t1.layer = 5'h1F;
        t1.x1[0] = 8'd16; t1.x2[0] = 8'd32; t1.y1[0] = 8'd8; t1.y2[0] = 8'd16;
        t1.wctl[0] = pe_win_ctl_t'{effects: 1'b1, layers: 5'b00011};
        t1.uctl = 6'b000100;

        // Overlapping windows for the priority checks
        t2 = '0;
        t2.layer = 5'h1F;
        t2.x1[0] = 8'd40; t2.x2[0] = 8'd60; t2.y1[0] = 8'd40; t2.y2[0] = 8'd60;
        t2.x1[1] = 8'd45; t2.x2[1] = 8'd70; t2.y1[1] = 8'd45; t2.y2[1] = 8'd70;
        t2.wctl[0] = 6'b000001; t2.wctl[1] = 6'b000010;
        t2.octl = 6'b101000; t2.uctl = 6'b000100;

        // Wrapping X range and wrapping Y range covering line 10
        t3 = '0;
        t3.en = 3'b001; t3.layer = 5'h1F;
        t3.x1[0] = 8'd200; t3.x2[0] = 8'd16; t3.y1[0] = 8'd200; t3.y2[0] = 8'd100;
        t3.wctl[0] = 6'(1 << LAYER_BG0); t3.uctl = 6'b000100;

        vecs.push_back(mk("t1_inside",   t1, 20, 10, 0, 5'b00011, 1'b1, 3'b001));
        vecs.push_back(mk("t1_outside",  t1, 40, 10, 0, 5'b00100, 1'b0, 3'b000));
        vecs.push_back(mk("t1_lo_edge",  t1, 16,  8, 0, 5'b00011, 1'b1, 3'b001));
        vecs.push_back(mk("t1_x_hi_edge", t1, 32, 10, 0, 5'b00100, 1'b0, 3'b000));
        vecs.push_back(mk("t1_y_hi_edge", t1, 20, 16, 0, 5'b00100, 1'b0, 3'b000));
        t4 = t1; t4.layer = 5'b11110;
        vecs.push_back(mk("t1_layer_gate", t4, 20, 10, 0, 5'b00010, 1'b1, 3'b001));
        t4 = t2; t4.en = 3'b111;
        vecs.push_back(mk("prio_win0",  t4, 50, 50, 1, 5'b00001, 1'b0, 3'b001));
        t4.en = 3'b110;
        vecs.push_back(mk("prio_win1",  t4, 50, 50, 1, 5'b00010, 1'b0, 3'b010));
        t4.en = 3'b100;
        vecs.push_back(mk("prio_obj",   t4, 50, 50, 1, 5'b01000, 1'b1, 3'b100));
        vecs.push_back(mk("prio_out",   t4, 50, 50, 0, 5'b00100, 1'b0, 3'b000));
        t4.en = 3'b000; t4.layer = 5'h15;
        vecs.push_back(mk("bypass",     t4, 50, 50, 1, 5'b10101, 1'b1, 3'b000));
        vecs.push_back(mk("wrap_x0",    t3,   0, 10, 0, 5'b00001, 1'b0, 3'b001));
        vecs.push_back(mk("wrap_x15",   t3,  15, 10, 0, 5'b00001, 1'b0, 3'b001));
        vecs.push_back(mk("wrap_x200",  t3, 200, 10, 0, 5'b00001, 1'b0, 3'b001));
        vecs.push_back(mk("wrap_x239",  t3, 239, 10, 0, 5'b00001, 1'b0, 3'b001));
        vecs.push_back(mk("wrap_x16",   t3,  16, 10, 0, 5'b00100, 1'b0, 3'b000));
        vecs.push_back(mk("wrap_x199",  t3, 199, 10, 0, 5'b00100, 1'b0, 3'b000));
        t4 = t3; t4.x1[0] = 8'd50; t4.x2[0] = 8'd50;
        vecs.push_back(mk("empty_x50",  t4,  50, 10, 0, 5'b00100, 1'b0, 3'b000));
        vecs.push_back(mk("empty_x0",   t4,   0, 10, 0, 5'b00100, 1'b0, 3'b000));

        repeat (2) @(negedge clock);
        check("reset_state", {mask_out, effects_out, out_valid, win_hit}, 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Counters: full line, V_LINES wrap, exact 2-cycle latency
        cfg = '0;
        cfg.en = 3'b001; cfg.layer = 5'h1F;
        cfg.x1[0] = 8'd0; cfg.x2[0] = 8'd255; cfg.y1[0] = 8'd0; cfg.y2[0] = 8'd1;
        cfg.wctl[0] = 6'b100001;
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        repeat (DEF_H_PIX) drive(0, 0, 1, 0);
        repeat (VL - 1) drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("y_last_line_miss", 32'(win_hit), 32'd0);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        check("latency_cycle1", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0);
        check("y_wrap_hit", {out_valid, win_hit}, {1'b1, 3'b001});
        drive(0, 0, 0, 0);
        check("latency_no_extra", 32'(out_valid), 32'd0);
        repeat (4) drive(0, 0, 0, 0);

        // X saturates at 255 on an overlong line
        cfg.x1[0] = 8'd255; cfg.x2[0] = 8'd0;
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 0);
        repeat (300) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("x_saturate", {out_valid, win_hit}, {1'b1, 3'b001});

        // Mid-frame bound change
        cfg = t1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        goto_xy(20, 10);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("shadow_before", 32'(win_hit), 32'b001);
        cfg.x1[0] = 8'd22;
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
`ifdef PE_WIN_SHADOW_EN
        check("shadow_midframe", 32'(win_hit), 32'b001);
`else
        check("live_midframe", 32'(win_hit), 32'b000);
`endif
        goto_xy(21, 10);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        check("next_frame_bound", 32'(win_hit), 32'b000);

        // Asynchronous reset mid-line
        cfg = t1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        goto_xy(20, 10);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        #2;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        pix_valid   = 1'b0;
        obj_win     = 1'b0;
        exp_q.delete();
        mx = 0;
        my = 0;
        sh = '0;
        #1 check("async_reset", {mask_out, effects_out, out_valid, win_hit}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        drive(0, 0, 1, 0);
        check("post_reset_lat1", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 0);
`ifdef PE_WIN_SHADOW_EN
        check("post_reset_pix", {out_valid, mask_out, effects_out, win_hit},
              {1'b1, 5'b00000, 1'b1, 3'b000});
`else
        check("post_reset_pix", {out_valid, mask_out, effects_out, win_hit},
              {1'b1, 5'b00100, 1'b0, 3'b000});
`endif
        drive(0, 0, 0, 0);

        // Random frames: configuration changes only while the pipeline is idle
        for (int f = 0; f < 6; f++) begin
            drive(0, 0, 0, 0);
            drive(0, 0, 0, 0);
            cfg.en    = 3'($urandom_range(0, 7));
            cfg.layer = 5'($urandom);
            for (int w = 0; w < 2; w++) begin
                cfg.x1[w]   = 8'($urandom_range(0, 47));
                cfg.x2[w]   = ($urandom_range(0, 7) == 0) ? cfg.x1[w] : 8'($urandom_range(0, 47));
                cfg.y1[w]   = 8'($urandom_range(0, 11));
                cfg.y2[w]   = 8'($urandom_range(0, 11));
                cfg.wctl[w] = 6'($urandom);
            end
            cfg.octl = 6'($urandom);
            cfg.uctl = 6'($urandom);
            drive(1, 1, 0, 0);
            for (int l = 0; l < 10; l++) begin
                drive(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat (50) drive(0, 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end
        repeat (3) drive(0, 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
